// File: rtl/cnu_msg_gen.sv
// cnu_msg_gen: expansion half of the check-node unit.
// Regenerates D sign-magnitude check-to-variable messages, one per cycle,
// from a compressed {min, min2, min_idx, signs} record held in a 2-entry buffer.
// Optional build macro: CNU_OFFSET_EN (offset-min-sum, subtract BETA saturating at 0).
module cnu_msg_gen #(
    parameter int data_w = 9,
    parameter int D      = 7,
    parameter int idx_w  = 3,
    parameter int BETA   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [data_w-1:0] in_min,
    input  logic [data_w-1:0] in_min2,
    input  logic [idx_w-1:0]  in_min_idx,
    input  logic [D-1:0]      in_signs,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [data_w:0]   out_msg,
    output logic [idx_w-1:0]  out_edge,
    output logic              out_last
);

`ifdef CNU_OFFSET_EN
    localparam int OFFSET_ON = 1;
`else
    localparam int OFFSET_ON = 0;
`endif

    // With the offset disabled this is zero and the subtraction below is a pass-through.
    localparam logic [data_w-1:0] OFFSET    = data_w'(BETA * OFFSET_ON);
    localparam logic [idx_w-1:0]  LAST_EDGE = idx_w'(D - 1);

    // Saturating offset: never wraps below zero.
    function automatic logic [data_w-1:0] f_sat_offset(input logic [data_w-1:0] mag);
        return (mag > OFFSET) ? (mag - OFFSET) : '0;
    endfunction

    // Record buffer storage (data only, not reset)
    logic [data_w-1:0] r_min   [2];
    logic [data_w-1:0] r_min2  [2];
    logic [idx_w-1:0]  r_idx   [2];
    logic [D-1:0]      r_signs [2];
    logic              r_par   [2];

    // Control state
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic [idx_w-1:0]  r_edge;

    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_fire;
    logic              w_pop;
    logic              w_sign;
    logic [data_w-1:0] w_mag;
    logic [D-1:0]      w_head_signs;

    assign w_empty   = (r_count == 2'd0);
    assign w_full    = (r_count == 2'd2);
    assign in_ready  = !w_full;
    assign w_push    = in_valid && !w_full;
    assign w_fire    = !w_empty && out_ready;
    assign w_pop     = w_fire && (r_edge == LAST_EDGE);

    // Capture an accepted record with its sign parity into the write slot.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_min[r_wr_ptr]   <= in_min;
            r_min2[r_wr_ptr]  <= in_min2;
            r_idx[r_wr_ptr]   <= in_min_idx;
            r_signs[r_wr_ptr] <= in_signs;
            r_par[r_wr_ptr]   <= ^in_signs;
        end
    end

    // Pointers, occupancy and edge counter; reset discards every buffered record.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_edge   <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            if (w_fire)
                r_edge <= (r_edge == LAST_EDGE) ? '0 : r_edge + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Regenerate the message for the current edge from the head record only.
    always_comb begin
        w_head_signs = r_signs[r_rd_ptr];
        w_sign       = r_par[r_rd_ptr];
        for (int i = 0; i < D; i++) begin
            if (r_edge == idx_w'(i))
                w_sign = r_par[r_rd_ptr] ^ w_head_signs[i];
        end
        w_mag = (r_edge == r_idx[r_rd_ptr]) ? r_min2[r_rd_ptr] : r_min[r_rd_ptr];
    end

    assign out_valid = !w_empty;
    assign out_edge  = r_edge;
    assign out_last  = !w_empty && (r_edge == LAST_EDGE);
    assign out_msg   = w_empty ? '0 : {w_sign, f_sat_offset(w_mag)};

endmodule

// File: tb/tb_cnu_msg_gen.sv
// Directed bench for cnu_msg_gen (default D=7, data_w=9, idx_w=3, BETA=1).
// Expected messages come from hand tables and a small reference model that
// follows the CNU_OFFSET_EN build macro.
module tb_cnu_msg_gen;

    localparam int DW = 9;
    localparam int DD = 7;
    localparam int IW = 3;
    localparam int BB = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_min;
    logic [DW-1:0] in_min2;
    logic [IW-1:0] in_min_idx;
    logic [DD-1:0] in_signs;
    logic          out_valid;
    logic          out_ready;
    logic [DW:0]   out_msg;
    logic [IW-1:0] out_edge;
    logic          out_last;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [DW-1:0] mn;
        logic [DW-1:0] mn2;
        logic [IW-1:0] idx;
        logic [DD-1:0] sg;
    } rec_t;

    // Hand-computed stream for min=3, min2=10, min_idx=2, signs=0000101.
`ifdef CNU_OFFSET_EN
    localparam logic [DW:0] T1 [DD] = '{10'h202, 10'h002, 10'h209, 10'h002, 10'h002, 10'h002, 10'h002};
`else
    localparam logic [DW:0] T1 [DD] = '{10'h203, 10'h003, 10'h20A, 10'h003, 10'h003, 10'h003, 10'h003};
`endif

    always #5 clk = ~clk;

    cnu_msg_gen #(
        .data_w (DW),
        .D      (DD),
        .idx_w  (IW),
        .BETA   (BB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_min     (in_min),
        .in_min2    (in_min2),
        .in_min_idx (in_min_idx),
        .in_signs   (in_signs),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_msg    (out_msg),
        .out_edge   (out_edge),
        .out_last   (out_last)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW:0] model(input rec_t r, input int e);
        logic [DW-1:0] m;
        logic          s;
        m = (int'(r.idx) == e) ? r.mn2 : r.mn;
`ifdef CNU_OFFSET_EN
        m = (m > DW'(BB)) ? m - DW'(BB) : '0;
`endif
        s = (^r.sg) ^ r.sg[e];
        return {s, m};
    endfunction

    task automatic drive_rec(input rec_t r);
        in_valid   = 1'b1;
        in_min     = r.mn;
        in_min2    = r.mn2;
        in_min_idx = r.idx;
        in_signs   = r.sg;
    endtask

    // Check edges first_e..last_e of record r, consuming one per cycle;
    // optionally hold out_ready low for stall_n cycles at edge stall_e.
    task automatic expect_msgs(input rec_t r, input int first_e, input int last_e,
                               input int stall_e, input int stall_n);
        for (int e = first_e; e <= last_e; e++) begin
            if (e == stall_e) begin
                out_ready = 1'b0;
                for (int k = 0; k < stall_n; k++) begin
                    step();
                    chk($sformatf("stall valid e%0d", e), 32'(out_valid), 32'd1);
                    chk($sformatf("stall edge e%0d", e), 32'(out_edge), 32'(e));
                    chk($sformatf("stall msg e%0d", e), 32'(out_msg), 32'(model(r, e)));
                end
                out_ready = 1'b1;
            end
            chk($sformatf("valid e%0d", e), 32'(out_valid), 32'd1);
            chk($sformatf("edge e%0d", e), 32'(out_edge), 32'(e));
            chk($sformatf("msg e%0d", e), 32'(out_msg), 32'(model(r, e)));
            chk($sformatf("last e%0d", e), 32'(out_last), 32'(e == DD - 1));
            step();
        end
    endtask

    rec_t r_t1, r_sat, r_a, r_b, r_c, r_d, r_hi;

    initial begin
        r_t1  = '{mn: 9'd3,   mn2: 9'd10,  idx: 3'd2, sg: 7'b0000101};
        r_sat = '{mn: 9'd0,   mn2: 9'd1,   idx: 3'd5, sg: 7'b1000000};
        r_a   = '{mn: 9'd17,  mn2: 9'd40,  idx: 3'd0, sg: 7'b0110011};
        r_b   = '{mn: 9'd5,   mn2: 9'd6,   idx: 3'd6, sg: 7'b1111111};
        r_c   = '{mn: 9'd100, mn2: 9'd511, idx: 3'd3, sg: 7'b0101010};
        r_d   = '{mn: 9'd1,   mn2: 9'd2,   idx: 3'd1, sg: 7'b0000001};
        r_hi  = '{mn: 9'd8,   mn2: 9'd200, idx: 3'd7, sg: 7'b1010100};

        rst = 1'b1; in_valid = 1'b0; in_min = '0; in_min2 = '0;
        in_min_idx = '0; in_signs = '0; out_ready = 1'b1;
        step(); step();
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_edge", 32'(out_edge), 32'd0);
        chk("rst out_msg", 32'(out_msg), 32'd0);
        chk("rst out_last", 32'(out_last), 32'd0);
        rst = 1'b0;
        step();
        chk("idle out_valid", 32'(out_valid), 32'd0);

        // Single record against the hand table
        drive_rec(r_t1);
        step();
        in_valid = 1'b0;
        for (int e = 0; e < DD; e++) begin
            chk($sformatf("t1 valid e%0d", e), 32'(out_valid), 32'd1);
            chk($sformatf("t1 edge e%0d", e), 32'(out_edge), 32'(e));
            chk($sformatf("t1 msg e%0d", e), 32'(out_msg), 32'(T1[e]));
            chk($sformatf("t1 last e%0d", e), 32'(out_last), 32'(e == DD - 1));
            step();
        end
        chk("t1 drained", 32'(out_valid), 32'd0);

        // Zero / near-zero magnitudes (saturation boundary under offset)
        drive_rec(r_sat);
        step();
        in_valid = 1'b0;
        expect_msgs(r_sat, 0, DD - 1, -1, 0);
        chk("sat drained", 32'(out_valid), 32'd0);

        // Backpressure at edge 4 for 3 cycles
        drive_rec(r_a);
        step();
        in_valid = 1'b0;
        expect_msgs(r_a, 0, DD - 1, 4, 3);
        chk("bp drained", 32'(out_valid), 32'd0);

        // Buffer full: three records back-to-back with the sink stalled
        out_ready = 1'b0;
        drive_rec(r_a);
        step();
        chk("full after 1 in_ready", 32'(in_ready), 32'd1);
        drive_rec(r_b);
        step();
        chk("full after 2 in_ready", 32'(in_ready), 32'd0);
        drive_rec(r_c);
        step(); step();
        chk("full hold in_ready", 32'(in_ready), 32'd0);
        chk("full head msg", 32'(out_msg), 32'(model(r_a, 0)));
        out_ready = 1'b1;
        expect_msgs(r_a, 0, DD - 1, -1, 0);
        chk("full reopen in_ready", 32'(in_ready), 32'd1);
        expect_msgs(r_b, 0, 0, -1, 0);
        in_valid = 1'b0;
        expect_msgs(r_b, 1, DD - 1, -1, 0);
        expect_msgs(r_c, 0, DD - 1, -1, 0);
        chk("full drained", 32'(out_valid), 32'd0);

        // Push coinciding with pop of the only record; min_idx beyond D
        drive_rec(r_d);
        step();
        in_valid = 1'b0;
        expect_msgs(r_d, 0, DD - 2, -1, 0);
        chk("pp last edge", 32'(out_edge), 32'(DD - 1));
        chk("pp last flag", 32'(out_last), 32'd1);
        chk("pp in_ready", 32'(in_ready), 32'd1);
        drive_rec(r_hi);
        step();
        in_valid = 1'b0;
        expect_msgs(r_hi, 0, DD - 1, -1, 0);
        chk("pp drained", 32'(out_valid), 32'd0);

        // Reset mid-record with both entries occupied
        out_ready = 1'b0;
        drive_rec(r_a);
        step();
        drive_rec(r_b);
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        expect_msgs(r_a, 0, 2, -1, 0);
        chk("mid edge before rst", 32'(out_edge), 32'd3);
        rst = 1'b1;
        step();
        chk("mid rst out_valid", 32'(out_valid), 32'd0);
        chk("mid rst in_ready", 32'(in_ready), 32'd1);
        chk("mid rst out_edge", 32'(out_edge), 32'd0);
        chk("mid rst out_msg", 32'(out_msg), 32'd0);
        rst = 1'b0;
        step();
        chk("post rst idle", 32'(out_valid), 32'd0);
        drive_rec(r_c);
        step();
        in_valid = 1'b0;
        expect_msgs(r_c, 0, DD - 1, -1, 0);
        chk("post rst drained", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cnu_msg_gen.md
Name: cnu_msg_gen

Overview:
- Expansion half of the check-node unit: takes one compressed check-node record (min, min2, min_idx, per-edge sign bits) and regenerates the D check-to-variable messages, one per cycle, in sign-magnitude form.
- Sits after the min/min2 finder and before the variable-node message router.
- Holds a 2-entry record buffer so the finder can run one record ahead of the serial output.

Parameters:
- data_w, 9, magnitude width of min/min2 and of the output magnitude.
- D, 7, check-node degree (messages per record); legal 2..8.
- idx_w, 3, width of min_idx and edge counter; must satisfy 2^idx_w >= D.
- BETA, 1, offset subtracted from magnitudes when CNU_OFFSET_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  compressed record valid
- in_ready  out  1  record buffer can accept
- in_min  in  data_w  smallest magnitude
- in_min2  in  data_w  second smallest magnitude
- in_min_idx  in  idx_w  edge index of in_min
- in_signs  in  D  sign of each incoming variable-to-check message, bit i = edge i
- out_valid  out  1  message valid
- out_ready  in  1  downstream accepts message
- out_msg  out  data_w+1  {sign, magnitude} for edge out_edge
- out_edge  out  idx_w  edge index of out_msg, 0..D-1
- out_last  out  1  high with edge D-1 of a record

Behaviour:
- Reset: clk, rst synchronous active-high. Buffer empty, wr/rd pointers 0, edge counter 0, out_valid=0, out_last=0, out_edge=0, out_msg=0, in_ready=1. A reset mid-record discards all buffered and partially sent records; no message is emitted in the cycle after reset.
- Buffer: 2 entries, each {min, min2, min_idx, signs, parity}. parity = XOR of in_signs, computed at push.
- Push occurs when in_valid && in_ready. in_ready = !full, registered-state only, with no same-cycle bypass. When full, a simultaneous pop does not raise in_ready in that cycle.
- Output fields are driven only from registered state (head entry and edge counter); there is no combinational path from in_* to out_*.
- out_valid = !empty. A record pushed in cycle N produces its first out_valid in cycle N+1 if the buffer was empty.
- Message for edge e:
  - magnitude = (e == min_idx) ? min2 : min
  - sign = parity XOR signs[e]
- Edge counter increments when out_valid && out_ready.
  - At e == D-1 the counter wraps to 0 and the head entry is popped in the same cycle.
  - out_last = out_valid && (e == D-1).
- out_valid && !out_ready: all out_* hold stable, and the counter and pointers are unchanged.
- Simultaneous push and pop with 1 entry: occupancy stays 1 and the new record becomes head after the pop.
- Pointers wrap modulo 2. Occupancy is tracked by a 2-bit count (0..2).
- If min_idx >= D, no edge matches, so every edge carries min. This is not an error.

Optional Feature:
- CNU_OFFSET_EN defined: output magnitude = max(selected - BETA, 0), saturating at 0 and never wrapping. Sign is unchanged, including when the magnitude becomes 0.
- Not defined: magnitude passed through unmodified and BETA is ignored.

Test Plan:
- Reset then single record, D=7, min=3, min2=10, min_idx=2, signs=7'b0000101, out_ready=1 -> parity=0. Seven messages, edges 0..6, one per cycle starting one cycle after accept. Edge 2 is {1,10}; edges 0 and 2 have sign 1, others sign 0. Magnitude is 3 on edges 0,1,3..6. out_last is high only on edge 6.
- Same record with CNU_OFFSET_EN, BETA=1 -> magnitudes 2 and 9. Second record min=0, min2=1 -> magnitudes 0 and 0, and no underflow to 511.
- Backpressure: out_ready low for 3 cycles at edge 4 -> out_msg and out_edge held at edge 4 values; the stream resumes at edge 4 without skipping or duplicating.
- Buffer full: push 3 records back-to-back with out_ready=0 -> in_ready drops after 2 accepts, and the third is held until the first record's edge 6 handshake completes. Output order is record 0, then 1, then 2.
- Simultaneous push/pop: push a new record in the same cycle as edge 6 of the only buffered record -> the new record's edge 0 appears the next cycle with no bubble.
- Reset asserted during edge 3 of a record with 2 buffered -> the next cycle has out_valid=0 and in_ready=1, and the next accepted record starts at edge 0.
